// File: rtl/accelerator_pkg.sv
// Shared types and constants for the accelerator sequencers.
package accelerator_pkg;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_READ = 1'b1
   } seq_state_t;

   localparam int SEQ_MAX_GROUP = 4;

   // 128-bit register holds 16 >> vsew elements
   function automatic logic [4:0] elems_per_cycle(input logic [1:0] vsew);
      return 5'd16 >> vsew;
   endfunction

endpackage

// File: rtl/seq_mask_gen.sv
// Writeback byte mask and 32b-lane count for one data cycle of a vector sequencer.
module seq_mask_gen
   import accelerator_pkg::*;
#(
   parameter int VL_W = 5
) (
   input  logic [1:0]      vsew,
   input  logic [VL_W-1:0] remaining,
   input  logic            reduction,
   output logic [15:0]     wb_byte_en,
   output logic [1:0]      elements_to_write,
   output logic            last
);

   localparam int CW = (VL_W > 5) ? VL_W : 5;

   logic [CW-1:0] rem_w;
   logic [CW-1:0] epc_w;
   logic [CW-1:0] count;
   logic [4:0]    full_bytes;
   logic [4:0]    mask_bytes;
   logic [5:0]    word_count;

   always_comb begin
      rem_w      = CW'(remaining);
      epc_w      = CW'(elems_per_cycle(vsew));
      last       = (rem_w <= epc_w);
      count      = last ? rem_w : epc_w;
      full_bytes = 5'(count[4:0] << vsew);
      // A reduction writes a single scalar element
      mask_bytes = reduction ? 5'(5'd1 << vsew) : full_bytes;
      word_count = (6'(full_bytes) + 6'd3) >> 2;
      elements_to_write = reduction ? count[1:0] : word_count[1:0];
   end

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_byte
         assign wb_byte_en[gi] = (5'(gi) < mask_bytes);
      end
   endgenerate

endmodule

// File: rtl/arith_sequencer.sv
// Sequences the 4-PE arithmetic stage over a vector register group: reads, then delayed data/writeback.
// Optional performance counters enabled by defining ARITH_SEQ_PERF_EN.
module arith_sequencer
   import accelerator_pkg::*;
#(
   parameter int VL_W      = 5,
   parameter int MAX_GROUP = SEQ_MAX_GROUP
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [VL_W-1:0] issue_vl,
   input  logic [1:0]      issue_vsew,
   input  logic            issue_reduction,
   input  logic            stall,
   output logic            rd_en,
   output logic [1:0]      rd_offset,
   output logic [1:0]      cycle_count,
   output logic [1:0]      elements_to_write,
   output logic            wb_en,
   output logic [1:0]      wb_offset,
   output logic [15:0]     wb_byte_en,
   output logic            done,
   output logic            err,
   output logic            busy
`ifdef ARITH_SEQ_PERF_EN
   ,
   output logic [31:0]     perf_active_cycles,
   output logic [31:0]     perf_stall_cycles
`endif
);

   localparam int LW = VL_W + 8;
   localparam int CW = (VL_W > 5) ? VL_W : 5;

   seq_state_t      state_reg, state_next;
   logic [1:0]      k_reg, k_next;
   logic [VL_W-1:0] rem_reg, rem_next;
   logic [1:0]      vsew_reg, vsew_next;
   logic            red_reg, red_next;

   logic            data_valid_reg, data_valid_next;
   logic [1:0]      data_k_reg, data_k_next;
   logic [VL_W-1:0] data_rem_reg, data_rem_next;
   logic [1:0]      data_vsew_reg, data_vsew_next;
   logic            data_red_reg, data_red_next;

   logic            err_reg, err_next;
   logic            zero_done_reg, zero_done_next;

   logic            accept;
   logic            illegal;
   logic            read_last;
   logic [4:0]      epc_read;
   logic [15:0]     mask_byte_en;
   logic [1:0]      mask_ete;
   logic            data_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= SEQ_IDLE;
         k_reg          <= '0;
         rem_reg        <= '0;
         vsew_reg       <= '0;
         red_reg        <= 1'b0;
         data_valid_reg <= 1'b0;
         data_k_reg     <= '0;
         data_rem_reg   <= '0;
         data_vsew_reg  <= '0;
         data_red_reg   <= 1'b0;
         err_reg        <= 1'b0;
         zero_done_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         k_reg          <= k_next;
         rem_reg        <= rem_next;
         vsew_reg       <= vsew_next;
         red_reg        <= red_next;
         data_valid_reg <= data_valid_next;
         data_k_reg     <= data_k_next;
         data_rem_reg   <= data_rem_next;
         data_vsew_reg  <= data_vsew_next;
         data_red_reg   <= data_red_next;
         err_reg        <= err_next;
         zero_done_reg  <= zero_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      k_next          = k_reg;
      rem_next        = rem_reg;
      vsew_next       = vsew_reg;
      red_next        = red_reg;
      data_valid_next = data_valid_reg;
      data_k_next     = data_k_reg;
      data_rem_next   = data_rem_reg;
      data_vsew_next  = data_vsew_reg;
      data_red_next   = data_red_reg;
      err_next        = err_reg;
      zero_done_next  = zero_done_reg;

      accept    = issue_valid && issue_ready;
      illegal   = (issue_vsew == 2'd3) ||
                  (LW'(issue_vl) > LW'(MAX_GROUP) * LW'(elems_per_cycle(issue_vsew)));
      epc_read  = elems_per_cycle(vsew_reg);
      read_last = (CW'(rem_reg) <= CW'(epc_read));

      if (!stall) begin
         err_next       = 1'b0;
         zero_done_next = 1'b0;
         // Data stage trails the read by the register-file latency of one cycle
         data_valid_next = (state_reg == SEQ_READ);
         data_k_next     = k_reg;
         data_rem_next   = rem_reg;
         data_vsew_next  = vsew_reg;
         data_red_next   = red_reg;

         if (state_reg == SEQ_READ) begin
            if (read_last) begin
               state_next = SEQ_IDLE;
            end else begin
               k_next   = k_reg + 2'd1;
               rem_next = rem_reg - VL_W'(epc_read);
            end
         end else if (accept) begin
            if (illegal) begin
               err_next = 1'b1;
            end else if (issue_vl == '0) begin
               zero_done_next = 1'b1;
            end else begin
               state_next = SEQ_READ;
               k_next     = 2'd0;
               rem_next   = issue_vl;
               vsew_next  = issue_vsew;
               red_next   = issue_reduction;
            end
         end
      end
   end

   seq_mask_gen #(
      .VL_W (VL_W)
   ) u_mask_gen (
      .vsew              (data_vsew_reg),
      .remaining         (data_rem_reg),
      .reduction         (data_red_reg),
      .wb_byte_en        (mask_byte_en),
      .elements_to_write (mask_ete),
      .last              (data_last)
   );

   // Reset forces every output low, including the ready that IDLE would otherwise raise
   assign issue_ready       = (state_reg == SEQ_IDLE) && !stall && !reset;
   assign rd_en             = (state_reg == SEQ_READ) && !stall;
   assign rd_offset         = (state_reg == SEQ_READ) ? k_reg : 2'd0;
   assign busy              = (state_reg == SEQ_READ) || data_valid_reg;
   assign cycle_count       = data_valid_reg ? data_k_reg : 2'd0;
   assign wb_offset         = (data_valid_reg && !data_red_reg) ? data_k_reg : 2'd0;
   assign wb_byte_en        = data_valid_reg ? mask_byte_en : 16'h0000;
   assign elements_to_write = data_valid_reg ? mask_ete : 2'd0;
   assign wb_en             = data_valid_reg && !stall && (!data_red_reg || data_last);
   assign done              = !stall && (zero_done_reg || (data_valid_reg && data_last));
   assign err               = err_reg && !stall;

`ifdef ARITH_SEQ_PERF_EN
   logic [31:0] perf_active_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_active_reg <= '0;
         perf_stall_reg  <= '0;
      end else if (busy) begin
         if (stall) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end else begin
            perf_active_reg <= perf_active_reg + 32'd1;
         end
      end
   end

   assign perf_active_cycles = perf_active_reg;
   assign perf_stall_cycles  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_arith_sequencer.sv
// Self-checking bench for arith_sequencer against a queue-based model of the read/data schedule.
module tb_arith_sequencer;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_vl;
   logic [1:0]  issue_vsew;
   logic        issue_reduction;
   logic        stall;
   logic        rd_en;
   logic [1:0]  rd_offset;
   logic [1:0]  cycle_count;
   logic [1:0]  elements_to_write;
   logic        wb_en;
   logic [1:0]  wb_offset;
   logic [15:0] wb_byte_en;
   logic        done;
   logic        err;
   logic        busy;
`ifdef ARITH_SEQ_PERF_EN
   logic [31:0] perf_active_cycles;
   logic [31:0] perf_stall_cycles;
`endif

   arith_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .issue_valid       (issue_valid),
      .issue_ready       (issue_ready),
      .issue_vl          (issue_vl),
      .issue_vsew        (issue_vsew),
      .issue_reduction   (issue_reduction),
      .stall             (stall),
      .rd_en             (rd_en),
      .rd_offset         (rd_offset),
      .cycle_count       (cycle_count),
      .elements_to_write (elements_to_write),
      .wb_en             (wb_en),
      .wb_offset         (wb_offset),
      .wb_byte_en        (wb_byte_en),
      .done              (done),
      .err               (err),
      .busy              (busy)
`ifdef ARITH_SEQ_PERF_EN
      ,
      .perf_active_cycles (perf_active_cycles),
      .perf_stall_cycles  (perf_stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: each accepted instruction becomes a list of pending reads; each read moves to the data stage one cycle later.
   typedef struct {
      int k;
      int rem;
      int sew;
      bit red;
   } item_t;

   item_t   m_rq[$];
   item_t   m_d;
   bit      m_dv = 0;
   bit      m_err = 0;
   bit      m_zd = 0;
   bit      in_rst = 0;
   longint  m_act = 0;
   longint  m_stl = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_outputs(input bit stl);
      int e, cnt, nb;
      bit last;
      logic [15:0] m;
      int x_cc, x_wo, x_ete, x_wb, x_rdo;
      last = 0; m = '0; x_cc = 0; x_wo = 0; x_ete = 0; x_wb = 0;
      x_rdo = (m_rq.size() > 0) ? m_rq[0].k : 0;
      if (m_dv) begin
         e    = 16 >> m_d.sew;
         cnt  = (m_d.rem < e) ? m_d.rem : e;
         last = (m_d.rem <= e);
         nb   = m_d.red ? (1 << m_d.sew) : (cnt << m_d.sew);
         for (int b = 0; b < 16; b++) m[b] = (b < nb);
         x_cc  = m_d.k;
         x_wo  = m_d.red ? 0 : m_d.k;
         x_ete = m_d.red ? (cnt % 4) : ((((cnt << m_d.sew) + 3) / 4) % 4);
         x_wb  = (!stl && (!m_d.red || last)) ? 1 : 0;
      end
      chk("issue_ready", 32'(issue_ready), 32'(!in_rst && m_rq.size() == 0 && !stl));
      chk("rd_en", 32'(rd_en), 32'(m_rq.size() > 0 && !stl));
      chk("rd_offset", 32'(rd_offset), 32'(x_rdo));
      chk("busy", 32'(busy), 32'(m_rq.size() > 0 || m_dv));
      chk("cycle_count", 32'(cycle_count), 32'(x_cc));
      chk("wb_offset", 32'(wb_offset), 32'(x_wo));
      chk("wb_byte_en", 32'(wb_byte_en), 32'(m));
      chk("elements_to_write", 32'(elements_to_write), 32'(x_ete));
      chk("wb_en", 32'(wb_en), 32'(x_wb));
      chk("done", 32'(done), 32'(!stl && (m_zd || (m_dv && last))));
      chk("err", 32'(err), 32'(m_err && !stl));
`ifdef ARITH_SEQ_PERF_EN
      chk("perf_active_cycles", perf_active_cycles, 32'(m_act));
      chk("perf_stall_cycles", perf_stall_cycles, 32'(m_stl));
`endif
   endtask

   task automatic step(input bit v, input int vl, input int sew, input bit red, input bit stl,
                       output bit acc);
      bit ready_m, busy_m;
      int e, n;
      item_t it;
      @(negedge clk);
      issue_valid     = v;
      issue_vl        = 5'(vl);
      issue_vsew      = 2'(sew);
      issue_reduction = red;
      stall           = stl;
      #1;
      compare_outputs(stl);
      ready_m = !in_rst && m_rq.size() == 0 && !stl;
      busy_m  = (m_rq.size() > 0) || m_dv;
      acc     = v && ready_m;
      @(posedge clk);
      if (busy_m) begin
         if (stl) m_stl++;
         else m_act++;
      end
      if (!stl) begin
         m_err = 0;
         m_zd  = 0;
         if (m_rq.size() > 0) begin
            m_d  = m_rq.pop_front();
            m_dv = 1;
         end else begin
            m_dv = 0;
         end
         if (acc) begin
            if (sew == 3) m_err = 1;
            else begin
               e = 16 >> sew;
               if (vl > 4 * e) m_err = 1;
               else if (vl == 0) m_zd = 1;
               else begin
                  n = (vl + e - 1) / e;
                  for (int k = 0; k < n; k++) begin
                     it.k = k; it.rem = vl - k * e; it.sew = sew; it.red = red;
                     m_rq.push_back(it);
                  end
               end
            end
         end
      end
   endtask

   task automatic issue(input int vl, input int sew, input bit red, input int stall_pct);
      bit acc;
      int tries;
      acc = 0;
      tries = 0;
      while (!acc && tries < 100) begin
         step(1, vl, sew, red, ($urandom_range(0, 99) < stall_pct), acc);
         tries++;
      end
      chk("issue_accepted", 32'(acc), 32'd1);
   endtask

   task automatic drain(input int stall_pct);
      bit acc;
      int tries;
      tries = 0;
      while ((m_rq.size() > 0 || m_dv || m_err || m_zd) && tries < 100) begin
         step(0, 0, 0, 0, ($urandom_range(0, 99) < stall_pct), acc);
         tries++;
      end
      step(0, 0, 0, 0, 0, acc);
   endtask

   initial begin
      bit acc;
      reset = 1'b1;
      in_rst = 1;
      issue_valid = 0; issue_vl = '0; issue_vsew = '0; issue_reduction = 0; stall = 0;
      #3;
      compare_outputs(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      in_rst = 0;

      issue(16, 2, 0, 0); drain(0);
      issue(6, 2, 0, 0);  drain(0);
      issue(7, 2, 1, 0);  drain(0);
      issue(20, 0, 0, 0); drain(0);
      issue(5, 3, 0, 0);  drain(0);
      issue(0, 2, 0, 0);  drain(0);
      issue(17, 2, 0, 0); drain(0);
      issue(31, 1, 1, 0); drain(0);

      // Stall held three cycles while READ sits at k=1
      issue(24, 1, 0, 0);
      step(0, 0, 0, 0, 0, acc);
      repeat (3) step(0, 0, 0, 0, 1, acc);
      drain(0);

      // Back-to-back: second instruction offered while the first drains
      issue(8, 2, 0, 0);
      issue(3, 2, 1, 0);
      drain(0);

      // Reset asserted during the data cycle of k=1
      issue(16, 2, 0, 0);
      step(0, 0, 0, 0, 0, acc);
      step(0, 0, 0, 0, 0, acc);
      @(negedge clk);
      issue_valid = 0; stall = 0;
      #1;
      compare_outputs(0);
      reset = 1'b1;
      in_rst = 1;
      m_rq.delete(); m_dv = 0; m_err = 0; m_zd = 0; m_act = 0; m_stl = 0;
      #1;
      compare_outputs(0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      in_rst = 0;
      issue(16, 2, 0, 0); drain(0);

      for (int i = 0; i < 40; i++) begin
         issue($urandom_range(0, 31), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 25);
         if ($urandom_range(0, 1) == 1) drain(25);
      end
      drain(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not terminate");
   end

endmodule
